// File: rtl/decoder_sequencer.sv
// Debounced four-switch sequencer that owns the 2-bit code word of the Go Board 2->4 LED decoder.
// Steps the code automatically (RUN) or by single-step presses (PAUSE), in WRAP or BOUNCE order.
module decoder_sequencer #(
  parameter int CLKS_PER_STEP = 12_500_000,
  parameter int DEBOUNCE_CLKS = 250_000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic [1:0] o_Code,
  output logic       o_Running,
  output logic       o_Dir,
  output logic       o_Mode,
  output logic       o_Step
);

  localparam int STEP_W = $clog2(CLKS_PER_STEP);
  localparam int DB_W   = $clog2(DEBOUNCE_CLKS + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CLKS_PER_STEP - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CLKS - 1);

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  logic [3:0] raw_sw;
  logic [3:0] press_ev;

  assign raw_sw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  // Per switch: two-flop synchronizer, hold-time debouncer, rising-edge press detector.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sw
      logic            meta_reg;
      logic            sync_reg;
      logic            stable_reg;
      logic            stable_d_reg;
      logic [DB_W-1:0] cnt_reg;

      always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
          meta_reg     <= 1'b0;
          sync_reg     <= 1'b0;
          stable_reg   <= 1'b0;
          stable_d_reg <= 1'b0;
          cnt_reg      <= '0;
        end else begin
          meta_reg     <= raw_sw[gi];
          sync_reg     <= meta_reg;
          stable_d_reg <= stable_reg;
          if (sync_reg == stable_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            cnt_reg    <= '0;
            stable_reg <= sync_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign press_ev[gi] = stable_reg & ~stable_d_reg;
    end
  endgenerate

  state_t            state_reg;
  logic [STEP_W-1:0] step_cnt_reg;
  logic [1:0]        code_reg;
  logic              dir_reg;
  logic              mode_reg;
  logic              step_reg;

  logic       dir_eff;
  logic       mode_eff;
  logic       timed_step;
  logic       manual_step;
  logic       do_step;
  logic [1:0] code_next;
  logic       dir_next;

  // Direction/mode toggles land before any coincident step so the step sees the new settings.
  // A pause press wins over a coincident terminal count: nothing moves on that edge.
  always_comb begin
    dir_eff     = dir_reg ^ press_ev[1];
    mode_eff    = mode_reg ^ press_ev[3];
    timed_step  = (state_reg == RUN) && !press_ev[0] && (step_cnt_reg == STEP_LAST);
    manual_step = (state_reg == PAUSE) && press_ev[2];
    do_step     = timed_step | manual_step;
    code_next   = code_reg;
    dir_next    = dir_eff;
    if (do_step) begin
      if (!mode_eff) begin
        code_next = dir_eff ? (code_reg - 2'd1) : (code_reg + 2'd1);
      end else if (!dir_eff) begin
        if (code_reg == 2'd3) begin
          code_next = 2'd2;
          dir_next  = 1'b1;
        end else begin
          code_next = code_reg + 2'd1;
        end
      end else begin
        if (code_reg == 2'd0) begin
          code_next = 2'd1;
          dir_next  = 1'b0;
        end else begin
          code_next = code_reg - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg    <= PAUSE;
      step_cnt_reg <= '0;
      code_reg     <= 2'd0;
      dir_reg      <= 1'b0;
      mode_reg     <= 1'b0;
      step_reg     <= 1'b0;
    end else begin
      code_reg <= code_next;
      dir_reg  <= dir_next;
      mode_reg <= mode_eff;
      step_reg <= do_step;
      case (state_reg)
        PAUSE: begin
          if (press_ev[0]) begin
            state_reg    <= RUN;
            step_cnt_reg <= '0;
          end
        end
        RUN: begin
          if (press_ev[0]) begin
            state_reg <= PAUSE;
          end else if (step_cnt_reg == STEP_LAST) begin
            step_cnt_reg <= '0;
          end else begin
            step_cnt_reg <= step_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= PAUSE;
      endcase
    end
  end

  assign o_Code    = code_reg;
  assign o_Running = (state_reg == RUN);
  assign o_Dir     = dir_reg;
  assign o_Mode    = mode_reg;
  assign o_Step    = step_reg;

endmodule
